io_word_uart_tx: RTL

Serial reporter for the processor's memory-mapped IO word. It sits downstream of the multi-cycle processor's `mem_map_io` output, alongside the LED tap. Whenever the word changes, it sends a 5-byte frame to the AVR over the board's FPGA-to-AVR serial line, `avr_rx`. It honours the AVR's receive-buffer-full flag, so the host sees every settled IO value without the processor stalling.

---
 rtl/io_word_uart_tx.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_word_uart_tx.sv
// -----------------------------------------------------------------------------
// io_word_uart_tx
//
// Reports the processor's memory-mapped IO word to the AVR over a plain 8N1
// serial line. Each time the word changes, the block sends a 5-byte frame:
//     HEADER, word[7:0], word[15:8], word[23:16], word[31:24]
// Every byte is LSB first, with one start bit (0) and one stop bit (1).
// Before each byte the block waits until the AVR's receive-buffer-full flag is
// clear. The processor is never stalled. Changes that arrive during a frame
// are merged, so only the newest value is sent when the frame ends.
//
// Parameters
//   CLK_RATE  clock frequency in Hz
//   BAUD      serial bit rate; CLK_RATE/BAUD must be an integer >= 2
//   HEADER    frame sync byte
//
// Ports
//   clk          in   system clock; all state updates on the rising edge
//   rst          in   synchronous, active-high reset
//   io_word      in   [31:0] memory-mapped IO word from the processor
//   avr_rx_busy  in   AVR receive buffer full (asynchronous, synchronised here)
//   tx           out  serial data to the AVR, idle high (registered)
//   busy         out  high while a frame is in progress (registered)
// -----------------------------------------------------------------------------
module io_word_uart_tx #(
    parameter int          CLK_RATE = 50000000,
    parameter int          BAUD     = 500000,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_word,
    input  logic        avr_rx_busy,
    output logic        tx,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SYNC_STAGES  = 2;
    localparam int FRAME_BYTES  = 5;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(FRAME_BYTES - 1);

    // Stop elaboration when the bit period cannot be a whole number of
    // clocks, or is too short for the counter scheme.
    if ((CLK_RATE % BAUD) != 0 || CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("io_word_uart_tx: CLK_RATE/BAUD must be an integer >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic [31:0]            last_sent_q, last_sent_d;
    logic [31:0]            snap_q,      snap_d;
    logic [BAUD_W-1:0]      baud_q,      baud_d;
    logic [2:0]             bit_q,       bit_d;
    logic [2:0]             byte_q,      byte_d;
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic                   tx_q,        tx_d;
    logic                   busy_q,      busy_d;

    logic                   avr_busy_sync;
    logic                   baud_last;
    logic [7:0]             cur_byte;
    logic [7:0]             frame_bytes [FRAME_BYTES];

    // -------------------------------------------------------------------------
    // Busy synchroniser. Each stage takes the previous one. After reset all
    // stages read 1, so the AVR counts as busy until a real 0 has passed
    // through the whole chain.
    // -------------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = avr_rx_busy;
        end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign avr_busy_sync = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Frame byte table. Slot 0 is the sync byte. Slots 1..4 are the
    // snapshot, least significant byte first.
    // -------------------------------------------------------------------------
    for (gi = 0; gi < FRAME_BYTES; gi++) begin : g_frame
        if (gi == 0) begin : g_hdr
            assign frame_bytes[gi] = HEADER;
        end else begin : g_data
            assign frame_bytes[gi] = snap_q[8*gi-8 +: 8];
        end
    end

    always_comb begin
        cur_byte = HEADER;
        case (byte_q)
            3'd0:    cur_byte = frame_bytes[0];
            3'd1:    cur_byte = frame_bytes[1];
            3'd2:    cur_byte = frame_bytes[2];
            3'd3:    cur_byte = frame_bytes[3];
            3'd4:    cur_byte = frame_bytes[4];
            default: cur_byte = HEADER;
        endcase
    end

    assign baud_last = (baud_q == BAUD_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic.
    // tx_d and busy_d come from the current state, not the next state. As a
    // result the outputs follow the state by one clock and depend only on
    // flops. The lag is the same for every bit, so bit widths are unchanged.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_sent_d = last_sent_q;
        snap_d      = snap_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        tx_d        = 1'b1;
        busy_d      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // io_word is sampled only here. Values that come and go
                // during a frame are never seen, so only the newest is sent.
                if (io_word != last_sent_q) begin
                    snap_d      = io_word;
                    last_sent_d = io_word;
                    byte_d      = 3'd0;
                    state_d     = S_WAIT_READY;
                end
            end

            S_WAIT_READY: begin
                // The AVR flag is checked only between bytes. Once a byte
                // has started, it always finishes.
                if (!avr_busy_sync) begin
                    baud_d  = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                tx_d = cur_byte[bit_q];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q < LAST_BYTE) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_WAIT_READY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // All flops. Reset drops any partial byte and drives the line high on the
    // next edge. last_sent is cleared, so a nonzero io_word present at reset
    // release starts a fresh frame.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_sent_q <= '0;
            snap_q      <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            sync_q      <= '1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_sent_q <= last_sent_d;
            snap_q      <= snap_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sync_q      <= sync_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
